// File: rtl/shreg_pkg.sv
// shreg_pkg: mode encodings shared by the universal shift register and its users.
package shreg_pkg;
    localparam int MODE_W = 3;
    localparam logic [MODE_W-1:0] M_HOLD = 3'd0;
    localparam logic [MODE_W-1:0] M_LOAD = 3'd1;
    localparam logic [MODE_W-1:0] M_SHL  = 3'd2;
    localparam logic [MODE_W-1:0] M_SHR  = 3'd3;
    localparam logic [MODE_W-1:0] M_ROL  = 3'd4;
    localparam logic [MODE_W-1:0] M_ROR  = 3'd5;
    localparam logic [MODE_W-1:0] M_ASR  = 3'd6;
    localparam logic [MODE_W-1:0] M_CLR  = 3'd7;
endpackage

// File: rtl/dffr_en.sv
// dffr_en: single-bit rising-edge flop with clock enable and async active-high reset to INIT.
module dffr_en #(
    parameter logic INIT = 1'b0
) (
    input  logic CK,
    input  logic RST,
    input  logic EN,
    input  logic D,
    output logic Q
);
    logic q_q, q_d;
    always_comb q_d = EN ? D : q_q;
    always_ff @(posedge CK or posedge RST) begin
        if (RST) q_q <= INIT;
        else     q_q <= q_d;
    end
    assign Q = q_q;
endmodule

// File: rtl/shreg_univ.sv
// shreg_univ: WIDTH-bit universal register (load, shift, rotate, arithmetic shift, clear)
// with a serial-out bit that remembers the last bit shifted or rotated out.
module shreg_univ
    import shreg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              EN,
    input  logic [MODE_W-1:0] MODE,
    input  logic [WIDTH-1:0]  D,
    input  logic              SIL,
    input  logic              SIR,
    output logic [WIDTH-1:0]  Q,
    output logic              SO,
    output logic              ZERO
);
    logic [WIDTH-1:0] q_q, q_d;
    logic             so_q, so_d;
    always_comb begin
        q_d  = q_q;
        so_d = so_q;
        case (MODE)
            M_HOLD: ;
            M_LOAD: q_d = D;
            M_SHL:  begin q_d = {q_q[WIDTH-2:0], SIL};       so_d = q_q[WIDTH-1]; end
            M_SHR:  begin q_d = {SIR, q_q[WIDTH-1:1]};       so_d = q_q[0];       end
            M_ROL:  begin q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]}; so_d = q_q[WIDTH-1]; end
            M_ROR:  begin q_d = {q_q[0], q_q[WIDTH-1:1]};    so_d = q_q[0];       end
            M_ASR:  begin q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]}; so_d = q_q[0];    end
            M_CLR:  begin q_d = '0;                          so_d = 1'b0;         end
            // Unknown mode: let X propagate rather than guess
            default: begin q_d = 'x; so_d = 1'bx; end
        endcase
    end
    for (genvar i = 0; i < WIDTH; i++) begin : g_q
        dffr_en #(.INIT(RESET_VAL[i])) u_q (
            .CK(CK), .RST(RST), .EN(EN), .D(q_d[i]), .Q(q_q[i])
        );
    end
    dffr_en #(.INIT(1'b0)) u_so (
        .CK(CK), .RST(RST), .EN(EN), .D(so_d), .Q(so_q)
    );
    assign Q    = q_q;
    assign SO   = so_q;
    assign ZERO = (q_q == '0);
endmodule

// File: tb/tb_shreg_univ.sv
// tb_shreg_univ: directed vectors with a queue scoreboard for 8-bit and 2-bit instances.
module tb_shreg_univ;
    import shreg_pkg::*;
    logic ck = 0, rst = 0, en8 = 0, en2 = 0, sil = 0, sir = 0;
    logic [2:0] mode = M_HOLD;
    logic [7:0] d8 = '0;
    logic [1:0] d2 = '0;
    logic [7:0] q8;
    logic [1:0] q2;
    logic so8, z8, so2, z2;
    typedef struct {
        string      name;
        bit         sel;
        logic [7:0] q;
        logic       so;
    } exp_t;
    exp_t sb[$];
    int total = 0, bad = 0;
    event smp;

    always #5 ck = ~ck;

    shreg_univ #(.WIDTH(8), .RESET_VAL(8'hA5)) u8 (
        .CK(ck), .RST(rst), .EN(en8), .MODE(mode), .D(d8), .SIL(sil), .SIR(sir),
        .Q(q8), .SO(so8), .ZERO(z8)
    );
    shreg_univ #(.WIDTH(2)) u2 (
        .CK(ck), .RST(rst), .EN(en2), .MODE(mode), .D(d2), .SIL(sil), .SIR(sir),
        .Q(q2), .SO(so2), .ZERO(z2)
    );

    always @(negedge ck or smp) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [7:0] aq;
            logic aso, az;
            e   = sb.pop_front();
            aq  = e.sel ? {6'b0, q2} : q8;
            aso = e.sel ? so2 : so8;
            az  = e.sel ? z2 : z8;
            total++;
            if (aq !== e.q || aso !== e.so || az !== (e.q == 8'h00)) begin
                bad++;
                $display("FAIL %s: got q=%h so=%b zero=%b, want q=%h so=%b zero=%b",
                         e.name, aq, aso, az, e.q, e.so, (e.q == 8'h00));
            end
        end
    end

    task automatic push(input string n, input bit s, input logic [7:0] q, input logic so);
        exp_t e;
        e.name = n; e.sel = s; e.q = q; e.so = so;
        sb.push_back(e);
    endtask

    task automatic step(input string n, input bit s, input logic e, input logic [2:0] m,
                        input logic [7:0] d, input logic sl, input logic sr,
                        input logic [7:0] eq, input logic eso);
        en8 = !s && e; en2 = s && e; mode = m; d8 = d; d2 = d[1:0]; sil = sl; sir = sr;
        @(posedge ck);
        #2;
        push(n, s, eq, eso);
    endtask

    localparam logic [7:0] ROL_Q[8]  = '{8'h2D, 8'h5A, 8'hB4, 8'h69, 8'hD2, 8'hA5, 8'h4B, 8'h96};
    localparam logic       ROL_SO[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        @(posedge ck);
        #2 rst = 1;
        #1;
        push("rst_async_w8", 0, 8'hA5, 1'b0);
        push("rst_async_w2", 1, 8'h00, 1'b0);
        ->smp;
        #2 rst = 0;
        step("en0_a", 0, 0, M_CLR, 8'h00, 0, 0, 8'hA5, 0);
        step("en0_b", 0, 0, M_LOAD, 8'hFF, 0, 0, 8'hA5, 0);
        step("load81", 0, 1, M_LOAD, 8'h81, 0, 0, 8'h81, 0);
        step("shl", 0, 1, M_SHL, 8'h00, 1, 0, 8'h03, 1);
        step("shr", 0, 1, M_SHR, 8'h00, 0, 0, 8'h01, 1);
        step("load96", 0, 1, M_LOAD, 8'h96, 0, 0, 8'h96, 1);
        for (int i = 0; i < 8; i++)
            step($sformatf("rol%0d", i + 1), 0, 1, M_ROL, 8'h00, 0, 0, ROL_Q[i], ROL_SO[i]);
        step("load80", 0, 1, M_LOAD, 8'h80, 0, 0, 8'h80, 0);
        step("asr1", 0, 1, M_ASR, 8'h00, 0, 0, 8'hC0, 0);
        step("asr2", 0, 1, M_ASR, 8'h00, 0, 0, 8'hE0, 0);
        step("asr3", 0, 1, M_ASR, 8'h00, 0, 0, 8'hF0, 0);
        step("clr", 0, 1, M_CLR, 8'h00, 0, 0, 8'h00, 0);
        step("load3c", 0, 1, M_LOAD, 8'h3C, 0, 0, 8'h3C, 0);
        en8 = 1; mode = M_SHL; sil = 1;
        @(posedge ck);
        rst = 1;
        #2;
        push("rst_on_edge", 0, 8'hA5, 0);
        rst = 0;
        step("shr_after_rst", 0, 1, M_SHR, 8'h00, 1, 0, 8'h52, 1);
        step("en0_clr", 0, 0, M_CLR, 8'h00, 0, 0, 8'h52, 1);
        step("ror", 0, 1, M_ROR, 8'h00, 0, 0, 8'h29, 0);
        step("w2_load", 1, 1, M_LOAD, 8'h02, 0, 0, 8'h02, 0);
        step("w2_ror1", 1, 1, M_ROR, 8'h00, 0, 0, 8'h01, 0);
        step("w2_ror2", 1, 1, M_ROR, 8'h00, 0, 0, 8'h02, 1);
        step("w2_shl1", 1, 1, M_SHL, 8'h00, 0, 0, 8'h00, 1);
        step("w2_shl2", 1, 1, M_SHL, 8'h00, 0, 0, 8'h00, 0);
        en8 = 0; en2 = 0;
        repeat (2) @(negedge ck);
        #1;
        if (sb.size() != 0) begin
            total += sb.size();
            bad += sb.size();
            $display("FAIL scoreboard_drain: got %0d unchecked, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
